aes_encrypt_iter: RTL and testbench
===================================

# aes_encrypt_iter

Iterative AES-128 encryption core: the forward counterpart of the decryption round datapath. It accepts one 128-bit plaintext block and one 128-bit cipher key per `start`, and runs the initial AddRoundKey plus ten rounds, one round per clock. It expands round keys on the fly and presents the ciphertext with a one-cycle `done` pulse. It sits beside the decryption path and produces the ciphertext that the decryption path consumes.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- `clk` input 1: rising-edge clock, single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request to encrypt; sampled only while `busy`=0.
- `inputdata` input 128: plaintext; sampled with `start`.
- `inkey` input 128: cipher key; sampled with `start`.
- `busy` output 1: high while a block is in flight.
- `done` output 1: one-cycle pulse; `r_out` is valid from this cycle.
- `r_out` output 128: ciphertext; held until the next completion.

## Operation
- Byte order follows FIPS-197: bits [127:120] are byte 0. The state is column-major, so column c is bytes 4c..4c+3.
- Registers:
  - 128-bit `state`.
  - 128-bit `rkey` (current round key).
  - 4-bit round counter `rnd`.
  - 8-bit `rcon`.
  - `busy`, `done`, `r_out`.
- States:
  - IDLE (`busy`=0).
  - RUN (`busy`=1, `rnd`=1..10).
- IDLE, `start`=1 → RUN on the next edge:
  - `state` ← `inputdata` ^ `inkey`.
  - `rkey` ← `inkey`.
  - `rnd` ← 1, `rcon` ← 8'h01.
- IDLE, `start`=0 → stay in IDLE; all registers hold.
- RUN, each edge:
  - Next round key: w0' = w0 ^ SubWord(RotWord(w3)) ^ {`rcon`,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'. w0 is `rkey`[127:96].
  - `rkey` ← next key.
  - `rcon` ← xtime(`rcon`), with xtime = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 0). This gives the sequence 01,02,04,08,10,20,40,80,1b,36.
- RUN, `rnd` 1..9: `state` ← MixColumns(ShiftRows(SubBytes(`state`))) ^ next key; `rnd` ← `rnd`+1.
- RUN, `rnd`=10:
  - `r_out` ← ShiftRows(SubBytes(`state`)) ^ next key (MixColumns is skipped).
  - `done` ← 1, `busy` ← 0, return to IDLE.
- The datapath reuses the team's forward SubBytes/ShiftRows/MixColumns blocks. SubWord uses the same forward S-box function, with four byte lookups.
- `start` while `busy`=1 is ignored. No queueing occurs and the in-flight block is unaffected.
- `inputdata` and `inkey` may change freely after the sampling edge.
- `done` is high for exactly one cycle per accepted block.
- Reset, async assert, at any time including mid-RUN:
  - `busy`=0, `done`=0, `r_out`=128'h0.
  - `state`, `rkey`, `rnd`=0, `rcon`=0; return to IDLE.
  - The in-flight block is discarded and no `done` follows.
  - Outputs change without waiting for a clock edge.
- Reset deassertion: the first edge with `rst_n`=1 may accept `start`.

## Timing
- `start` is sampled at edge E0. `busy` is high from just after E0.
- Round k completes at edge E0+k. Ciphertext registers at E0+10.
- `done`=1 and `r_out` are valid in the cycle after E0+10. Latency is 10 clocks, start edge to done edge.
- `busy` falls at the same edge E0+10 where `done` rises.
- Back-to-back: `start` held high during the `done` cycle is accepted at E0+11. Sustained throughput is one block per 11 clocks.
- `done` returns to 0 at E0+11 unless a later completion occurs, which is impossible before E0+21.
- Critical path is one round: S-box → ShiftRows (wiring) → MixColumns → XOR, in parallel with key expansion.

## Test plan
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 → `r_out` 3925841d02dc09fbdc118597196a0b32. `done` must rise exactly 10 edges after the start edge.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a. Immediately follow with all-zero key and all-zero plaintext, `start` asserted in the `done` cycle → 66e94bd4ef8a2c3b884cfa59ca342b2e, 11 clocks later.
- `start` pulsed at E0+3 and E0+7 with different data during a C.1 run → result is still 69c4e0d86a7b0430d8cdb78070b4c55a, with a single `done` pulse.
- Assert `rst_n`=0 mid-run at E0+5, asynchronously between edges → `busy`, `done` and `r_out` go to 0 immediately. No `done` after release. A fresh Appendix B run then passes.
- Hold `start`=0 for 50 cycles after a completion → `r_out` holds its last ciphertext, `done` stays 0 and `busy` stays 0.
- Change `inputdata` and `inkey` every cycle during a run → ciphertext matches the values sampled at the start edge only.

Source files
------------

// File: rtl/aes_encrypt_iter_if.sv
// Encryption request/result bundle for the iterative AES-128 core.
// The requester drives start/inputdata/inkey; the core returns busy/done/r_out.
interface aes_encrypt_iter_if;
    logic         start;
    logic [127:0] inputdata;
    logic [127:0] inkey;
    logic         busy;
    logic         done;
    logic [127:0] r_out;

    modport master (output start, inputdata, inkey, input busy, done, r_out);
    modport slave  (input start, inputdata, inkey, output busy, done, r_out);
endinterface

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// state | meaning
// IDLE  | waiting for start; r_out holds the last ciphertext
// RUN   | rounds 1..10 in flight, rnd names the round being computed
module aes_encrypt_iter (
    input  logic              clk,
    input  logic              rst_n,
    aes_encrypt_iter_if.slave bus
);
    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t         fsm, fsm_nxt;
    logic [127:0] state, state_nxt;
    logic [127:0] rkey, rkey_nxt;
    logic [127:0] r_out, r_out_nxt;
    logic [3:0]   rnd, rnd_nxt;
    logic [7:0]   rcon, rcon_nxt;
    logic         busy, busy_nxt;
    logic         done, done_nxt;

    logic [127:0] key_nxt, sub_shift, mixed;
    logic [31:0]  sub_word, w0n, w1n, w2n, w3n;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    // RotWord folded into the byte selection of SubWord
    assign sub_word = {sbox(rkey[23:16]), sbox(rkey[15:8]), sbox(rkey[7:0]), sbox(rkey[31:24])};
    assign w0n      = rkey[127:96] ^ sub_word ^ {rcon, 24'h0};
    assign w1n      = rkey[95:64] ^ w0n;
    assign w2n      = rkey[63:32] ^ w1n;
    assign w3n      = rkey[31:0]  ^ w2n;
    assign key_nxt  = {w0n, w1n, w2n, w3n};

    assign sub_shift = shift_rows(sub_bytes(state));
    assign mixed     = mix_columns(sub_shift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt   = fsm;
        state_nxt = state;
        rkey_nxt  = rkey;
        r_out_nxt = r_out;
        rnd_nxt   = rnd;
        rcon_nxt  = rcon;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (fsm)
            IDLE: begin
                if (bus.start) begin
                    fsm_nxt   = RUN;
                    state_nxt = bus.inputdata ^ bus.inkey;
                    rkey_nxt  = bus.inkey;
                    rnd_nxt   = 4'd1;
                    rcon_nxt  = 8'h01;
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                rkey_nxt = key_nxt;
                rcon_nxt = xtime(rcon);
                if (rnd == 4'd10) begin
                    r_out_nxt = sub_shift ^ key_nxt;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    fsm_nxt   = IDLE;
                end else begin
                    state_nxt = mixed ^ key_nxt;
                    rnd_nxt   = rnd + 4'd1;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
            rkey  <= '0;
            r_out <= '0;
            rnd   <= '0;
            rcon  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            rkey  <= rkey_nxt;
            r_out <= r_out_nxt;
            rnd   <= rnd_nxt;
            rcon  <= rcon_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.r_out = r_out;
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: FIPS-197 vectors, protocol corner cases and random
// blocks checked against a byte-array AES-128 reference model.
module tb_aes_encrypt_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    aes_encrypt_iter_if bus();
    aes_encrypt_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sbox_t[256];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    // S-box table built by walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w[44];
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   a[4];
        logic [31:0]  tw;
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {sbox_t[tw[23:16]], sbox_t[tw[15:8]], sbox_t[tw[7:0]], sbox_t[tw[31:24]]}
                     ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int j = 0; j < 16; j++) t[j] = sbox_t[s[j]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int rr = 0; rr < 4; rr++) a[rr] = s[4*c+rr];
                    for (int rr = 0; rr < 4; rr++)
                        s[4*c+rr] = xt(a[rr]) ^ xt(a[(rr+1)%4]) ^ a[(rr+1)%4]
                                    ^ a[(rr+2)%4] ^ a[(rr+3)%4];
                end
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
        end
        res = '0;
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic launch(input logic [127:0] pt, input logic [127:0] key);
        bus.start     = 1'b1;
        bus.inputdata = pt;
        bus.inkey     = key;
    endtask

    // Called at a negedge with start driven; returns at the negedge of the done cycle.
    // mode 1 scrambles inputs every cycle, mode 2 pulses start at E0+3 and E0+7.
    task automatic await_done(input int mode, input logic [127:0] exp, input string tag);
        int k;
        k = 0;
        @(posedge clk);
        while (k < 30) begin
            @(negedge clk);
            if (bus.done) break;
            if (k == 0) begin
                bus.start = 1'b0;
                check({tag, "_busy"}, 128'(bus.busy), 128'd1);
            end
            if (mode == 1) begin
                bus.inputdata = rnd128();
                bus.inkey     = rnd128();
            end
            if (mode == 2) begin
                if (k == 2 || k == 6) begin
                    bus.start     = 1'b1;
                    bus.inputdata = rnd128();
                    bus.inkey     = rnd128();
                end else if (k == 3 || k == 7) begin
                    bus.start = 1'b0;
                end
            end
            @(posedge clk);
            k++;
        end
        check({tag, "_latency"}, 128'(k), 128'd10);
        check({tag, "_ct"}, bus.r_out, exp);
        check({tag, "_busy_done"}, 128'(bus.busy), 128'd0);
    endtask

    task automatic idle_hold(input int n, input logic [127:0] exp, input string tag);
        bus.start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_done"}, 128'(bus.done), 128'd0);
            check({tag, "_busy"}, 128'(bus.busy), 128'd0);
            check({tag, "_rout"}, bus.r_out, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt, key, ct;
        build_sbox();
        bus.start     = 1'b0;
        bus.inputdata = '0;
        bus.inkey     = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_rout", bus.r_out, 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        launch(PT_B, KEY_B);
        await_done(0, CT_B, "fips_b");
        idle_hold(2, CT_B, "post_b");

        @(negedge clk);
        launch(PT_C, KEY_C);
        await_done(0, CT_C, "fips_c1");
        launch('0, '0);
        await_done(0, CT_Z, "b2b_zero");
        idle_hold(50, CT_Z, "hold50");

        launch(PT_C, KEY_C);
        await_done(2, CT_C, "ignore_start");
        idle_hold(3, CT_C, "single_done");

        launch(PT_B, KEY_B);
        await_done(1, CT_B, "scramble");
        idle_hold(1, CT_B, "post_scr");

        for (int i = 0; i < 8; i++) begin
            pt  = rnd128();
            key = rnd128();
            ct  = aes_ref(pt, key);
            launch(pt, key);
            await_done(0, ct, "rand");
            idle_hold(1, ct, "rand_idle");
        end

        @(negedge clk);
        launch(PT_C, KEY_C);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 128'(bus.busy), 128'd0);
        check("arst_done", 128'(bus.done), 128'd0);
        check("arst_rout", bus.r_out, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_hold(20, 128'd0, "after_rst");

        launch(PT_B, KEY_B);
        await_done(0, CT_B, "fresh_b");
        idle_hold(1, CT_B, "end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
